// File: rtl/issue_stage.sv
// -----------------------------------------------------------------------------
// issue_stage
//   Decode and operand-issue stage that sits directly in front of an alu.
//   It holds one instruction, reads its operands from a 32x64 register file
//   (r0 is hard zero) and issues the opcode and operands to the alu.
//   Alu results come back on the writeback port. A per-register pending
//   scoreboard stalls read-after-write and write-after-write hazards.
//
//   Optional feature: define ISSUE_BYPASS_EN to forward a same-edge writeback
//   into the operands. The forwarded register is then treated as not pending,
//   so the dependent instruction issues on the writeback edge.
//
// Ports
//   c          clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   instruction offered
//   in_instr   [31:24] opc, [23:19] rd, [18:14] rs1, [13:9] rs2,
//              [8] imm_sel, [7:0] imm
//   in_ready   instruction taken on an edge where in_valid & in_ready
//   iss_valid  one-cycle pulse marking iss_* as valid
//   iss_op     alu opcode (8'h80 = nop)
//   iss_a      operand a = R[rs1]
//   iss_b      operand b = imm_sel ? sext(imm) : R[rs2]
//   iss_rd     destination register, returned later on wb_rd
//   iss_ill    pulses with iss_valid when the opcode was illegal
//   wb_en      writeback strobe
//   wb_rd      writeback register
//   wb_data    writeback value
// -----------------------------------------------------------------------------
module issue_stage #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int IMMW = 8
) (
  input  logic            c,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [31:0]     in_instr,
  output logic            in_ready,
  output logic            iss_valid,
  output logic [7:0]      iss_op,
  output logic [XLEN-1:0] iss_a,
  output logic [XLEN-1:0] iss_b,
  output logic [4:0]      iss_rd,
  output logic            iss_ill,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data
);

`ifdef ISSUE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  localparam logic [7:0] OP_NOP = 8'h80;

  typedef enum logic {S_EMPTY, S_HELD} state_t;

  state_t                      state_q, state_d;
  logic [31:0]                 ir_q, ir_d;
  logic [NREG-1:0]             pend_q, pend_d;
  logic [NREG-1:0][XLEN-1:0]   rf_q, rf_d;
  logic                        iss_valid_q, iss_valid_d;
  logic [7:0]                  iss_op_q, iss_op_d;
  logic [XLEN-1:0]             iss_a_q, iss_a_d;
  logic [XLEN-1:0]             iss_b_q, iss_b_d;
  logic [4:0]                  iss_rd_q, iss_rd_d;
  logic                        iss_ill_q, iss_ill_d;

  // Decode of the held instruction
  logic [7:0]      opc;
  logic [4:0]      rd, rs1, rs2;
  logic            imm_sel;
  logic [IMMW-1:0] imm;
  logic            op_legal, op_nop, op_unary, uses_rs2;

  assign opc     = ir_q[31:24];
  assign rd      = ir_q[23:19];
  assign rs1     = ir_q[18:14];
  assign rs2     = ir_q[13:9];
  assign imm_sel = ir_q[8];
  assign imm     = ir_q[IMMW-1:0];

  assign op_legal = (opc[7:4] == 4'h0);
  assign op_nop   = (opc == OP_NOP);
  assign op_unary = (opc == 8'h07) || (opc == 8'h08) || (opc == 8'h0E) || (opc == 8'h0F);
  assign uses_rs2 = op_legal && !op_unary && !imm_sel;

  logic            wb_live, hazard, issue, accept;
  logic [NREG-1:0] pend_eff;
  logic [XLEN-1:0] opnd_a, opnd_b_reg, imm_ext;

  // r0 never takes a write, so it needs no pending bit or forwarding path.
  assign wb_live  = wb_en && (wb_rd != 5'd0);
  assign pend_eff = pend_q & ~((BYPASS && wb_live) ? (NREG'(1) << wb_rd) : '0);

  assign opnd_a     = (BYPASS && wb_live && (wb_rd == rs1)) ? wb_data : rf_q[rs1];
  assign opnd_b_reg = (BYPASS && wb_live && (wb_rd == rs2)) ? wb_data : rf_q[rs2];
  assign imm_ext    = {{(XLEN-IMMW){imm[IMMW-1]}}, imm};

  // Nops and illegal opcodes carry no register dependencies.
  assign hazard = op_legal &&
                  (((rs1 != 5'd0) && pend_eff[rs1]) ||
                   (uses_rs2 && (rs2 != 5'd0) && pend_eff[rs2]) ||
                   ((rd != 5'd0) && pend_eff[rd]));

  assign issue    = (state_q == S_HELD) && !hazard;
  assign in_ready = (state_q == S_EMPTY) || issue;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    pend_d      = pend_q;
    rf_d        = rf_q;
    iss_valid_d = issue;
    iss_ill_d   = issue && !op_legal && !op_nop;
    iss_op_d    = iss_op_q;
    iss_a_d     = iss_a_q;
    iss_b_d     = iss_b_q;
    iss_rd_d    = iss_rd_q;

    if (wb_live) begin
      rf_d[wb_rd]   = wb_data;
      pend_d[wb_rd] = 1'b0;
    end

    if (issue) begin
      if (op_legal) begin
        iss_op_d = opc;
        iss_a_d  = opnd_a;
        iss_b_d  = op_unary ? '0 : (imm_sel ? imm_ext : opnd_b_reg);
        iss_rd_d = rd;
        // Applied after the writeback clear so a same-edge set wins.
        if (rd != 5'd0) pend_d[rd] = 1'b1;
      end else begin
        iss_op_d = OP_NOP;
        iss_a_d  = '0;
        iss_b_d  = '0;
        iss_rd_d = 5'd0;
      end
    end

    if (accept) begin
      state_d = S_HELD;
      ir_d    = in_instr;
    end else if (issue) begin
      state_d = S_EMPTY;
    end
  end

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_EMPTY;
      ir_q        <= '0;
      pend_q      <= '0;
      rf_q        <= '0;
      iss_valid_q <= 1'b0;
      iss_op_q    <= OP_NOP;
      iss_a_q     <= '0;
      iss_b_q     <= '0;
      iss_rd_q    <= 5'd0;
      iss_ill_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      pend_q      <= pend_d;
      rf_q        <= rf_d;
      iss_valid_q <= iss_valid_d;
      iss_op_q    <= iss_op_d;
      iss_a_q     <= iss_a_d;
      iss_b_q     <= iss_b_d;
      iss_rd_q    <= iss_rd_d;
      iss_ill_q   <= iss_ill_d;
    end
  end

  assign iss_valid = iss_valid_q;
  assign iss_op    = iss_op_q;
  assign iss_a     = iss_a_q;
  assign iss_b     = iss_b_q;
  assign iss_rd    = iss_rd_q;
  assign iss_ill   = iss_ill_q;

endmodule
